// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM sequencing controller / arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    CLR    = 2'd3
  } state_e;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-request grant logic. SRAM_ARB_RR_EN selects round-robin with a priority
// pointer; otherwise request 0 always wins and no pointer exists.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               take_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef SRAM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // ptr_q = 1 means port 1 is preferred when both ports request.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && req_i[1]) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end else begin
      gnt_o = 2'b00;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i) begin
      ptr_d = gnt_o[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk_i, rst_i, take_i};

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end else begin
      gnt_o = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer and two-port arbiter driving the DFF-based 4x8 SRAM control pins.
// Arbitration policy: SRAM_ARB_RR_EN (round-robin) or fixed priority by default.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  input  logic              ClrReq,
  output logic              ClrAck,
  output logic [DATA_W-1:0] SramI,
  input  logic [DATA_W-1:0] SramO,
  output logic              Select0,
  output logic              Select1,
  output logic              Read,
  output logic              Clear
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                we_q, we_d, port_q, port_d;
  logic                read_q, read_d, clear_q, clear_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d, clrack_q, clrack_d;
  logic [NUM_REQ-1:0]  req_elig_s, gnt_s;
  logic                clr_elig_s, take_s;

  // A requester is ignored during its own Ack cycle so a still-held Req is not served twice.
  assign req_elig_s = {Req1 & ~ack1_q, Req0 & ~ack0_q};
  assign clr_elig_s = ClrReq & ~clrack_q;
  assign take_s     = (state_q == IDLE) && !clr_elig_s && (gnt_s != 2'b00);

  rr_arb2 u_arb (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .req_i  (req_elig_s),
    .take_i (take_s),
    .gnt_o  (gnt_s)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clr_elig_s) begin
          state_d = CLR;
        end else if (gnt_s != 2'b00) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = we_q ? STROBE : IDLE;
      STROBE:  state_d = IDLE;
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and write data are only loaded on a grant, so they stay put through the strobe.
  always_comb begin
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    port_d   = port_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    read_d   = 1'b1;
    clear_d  = 1'b1;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    clrack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_elig_s) begin
          clear_d = 1'b0;
        end else if (gnt_s != 2'b00) begin
          port_d  = gnt_s[1];
          sel_d   = gnt_s[1] ? Addr1  : Addr0;
          wdata_d = gnt_s[1] ? WData1 : WData0;
          we_d    = gnt_s[1] ? We1    : We0;
        end else begin
          clear_d = 1'b1;
        end
      end
      SETUP: begin
        if (we_q) begin
          read_d = 1'b0;
        end else if (port_q) begin
          rdata1_d = SramO;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = SramO;
          ack0_d   = 1'b1;
        end
      end
      STROBE: begin
        ack0_d = ~port_q;
        ack1_d = port_q;
      end
      CLR:     clrack_d = 1'b1;
      default: read_d   = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_q    <= 2'b00;
      wdata_q  <= 8'h00;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      read_q   <= 1'b1;
      clear_q  <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      clrack_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      port_q   <= port_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      read_q   <= read_d;
      clear_q  <= clear_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      clrack_q <= clrack_d;
    end
  end

  assign Select0 = sel_q[0];
  assign Select1 = sel_q[1];
  assign SramI   = wdata_q;
  assign Read    = read_q;
  assign Clear   = clear_q;
  assign Ack0    = ack0_q;
  assign Ack1    = ack1_q;
  assign ClrAck  = clrack_q;
  assign RData0  = rdata0_q;
  assign RData1  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural model of the DFF SRAM.
module tb_sram_arbiter;

  logic       Clk, Reset, Req0, Req1, We0, We1, ClrReq;
  logic [1:0] Addr0, Addr1;
  logic [7:0] WData0, WData1, SramO, SramI, RData0, RData1;
  logic       Ack0, Ack1, ClrAck, Select0, Select1, Read, Clear;

  int         n_cmp, n_err;
  logic [7:0] mem [4];
  int         ord_q [8];
  logic [7:0] ordd_q [8];
  int         ord_n;

  sram_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
    .ClrReq(ClrReq), .ClrAck(ClrAck),
    .SramI(SramI), .SramO(SramO),
    .Select0(Select0), .Select1(Select1), .Read(Read), .Clear(Clear)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM: falling Read stores SramI; falling Clear zeroes the array; mux gated by Read.
  always @(negedge Read or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    end else if (!Read) begin
      mem[{Select1, Select0}] = SramI;
    end
  end
  assign SramO = Read ? mem[{Select1, Select0}] : 8'h00;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic txn(input int port, input logic we, input logic [1:0] addr,
                     input logic [7:0] wd, output logic [7:0] rd, output int lat);
    lat = -1;
    rd  = 8'h00;
    if (port == 0) begin
      Req0 = 1'b1; We0 = we; Addr0 = addr; WData0 = wd;
    end else begin
      Req1 = 1'b1; We1 = we; Addr1 = addr; WData1 = wd;
    end
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      tick();
      if ((port == 0) ? Ack0 : Ack1) begin
        lat = i;
        rd  = (port == 0) ? RData0 : RData1;
      end
    end
    if (port == 0) Req0 = 1'b0; else Req1 = 1'b0;
    tick();
  endtask

  // Each requester drops Req in its Ack cycle and re-requests the next cycle while work remains.
  task automatic run_pair(input int n0, input int n1);
    int left0, left1;
    left0 = n0;
    left1 = n1;
    ord_n = 0;
    Req0  = (n0 > 0);
    Req1  = (n1 > 0);
    for (int i = 0; i < 80 && (left0 + left1) > 0; i++) begin
      tick();
      if (Ack0) begin
        if (ord_n < 8) begin ord_q[ord_n] = 0; ordd_q[ord_n] = RData0; end
        ord_n++; left0--; Req0 = 1'b0;
      end else begin
        Req0 = (left0 > 0);
      end
      if (Ack1) begin
        if (ord_n < 8) begin ord_q[ord_n] = 1; ordd_q[ord_n] = RData1; end
        ord_n++; left1--; Req1 = 1'b0;
      end else begin
        Req1 = (left1 > 0);
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; We0 = 1'b0; We1 = 1'b0; ClrReq = 1'b0;
    Addr0 = 2'd0; Addr1 = 2'd0; WData0 = 8'h00; WData1 = 8'h00;
    pulse_reset();
    n_cmp++;
    if ({Read, Clear, Select1, Select0} !== 4'b1100) begin
      n_err++; $display("FAIL reset_pins: got %b want 1100", {Read, Clear, Select1, Select0});
    end
    n_cmp++;
    if ({Ack0, Ack1, ClrAck} !== 3'b000) begin
      n_err++; $display("FAIL reset_acks: got %b want 000", {Ack0, Ack1, ClrAck});
    end
    n_cmp++;
    if ({SramI, RData0, RData1} !== 24'h000000) begin
      n_err++; $display("FAIL reset_data: got %h want 000000", {SramI, RData0, RData1});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({Read, Clear, Ack0, Ack1, ClrAck} !== 5'b11000) begin
        n_err++; $display("FAIL reset_idle cyc %0d: got %b want 11000", i, {Read, Clear, Ack0, Ack1, ClrAck});
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    int lat;
    Req0 = 1'b1; We0 = 1'b1; Addr0 = 2'd2; WData0 = 8'hA5;
    tick();
    n_cmp++;
    if ({Read, Select1, Select0, SramI, Ack0} !== {3'b110, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL wr_setup: got %b want 110_a5_0", {Read, Select1, Select0, SramI, Ack0});
    end
    tick();
    n_cmp++;
    if ({Read, Select1, Select0, SramI, Ack0} !== {3'b010, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL wr_strobe: got %b want 010_a5_0", {Read, Select1, Select0, SramI, Ack0});
    end
    tick();
    n_cmp++;
    if ({Read, Ack0, Select1, Select0} !== 4'b1110) begin
      n_err++; $display("FAIL wr_ack: got %b want 1110", {Read, Ack0, Select1, Select0});
    end
    Req0 = 1'b0;
    tick();
    n_cmp++;
    if ({Read, Ack0} !== 2'b10) begin
      n_err++; $display("FAIL wr_after: got %b want 10", {Read, Ack0});
    end
    txn(0, 1'b0, 2'd2, 8'h00, rd, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_err++; $display("FAIL rd_latency: got %0d want 2", lat);
    end
    n_cmp++;
    if (rd !== 8'hA5) begin
      n_err++; $display("FAIL rd_data: got %h want a5", rd);
    end
    n_cmp++;
    if (RData0 !== 8'hA5) begin
      n_err++; $display("FAIL rd_hold: got %h want a5", RData0);
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] rd;
    int lat;
    pulse_reset();
    tick();
    We0 = 1'b1; Addr0 = 2'd1; WData0 = 8'h11;
    We1 = 1'b1; Addr1 = 2'd3; WData1 = 8'h33;
    run_pair(2, 2);
    n_cmp++;
    if (ord_n !== 4) begin
      n_err++; $display("FAIL arb_wr_count: got %0d want 4", ord_n);
    end else begin
      n_cmp++;
      if ({ord_q[0], ord_q[1], ord_q[2], ord_q[3]} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
        n_err++; $display("FAIL arb_wr_order: got %0d%0d%0d%0d want 0101",
                          ord_q[0], ord_q[1], ord_q[2], ord_q[3]);
      end
    end
    txn(0, 1'b0, 2'd1, 8'h00, rd, lat);
    n_cmp++;
    if ({lat, rd} !== {32'd2, 8'h11}) begin
      n_err++; $display("FAIL arb_solo_rd: got lat %0d data %h want lat 2 data 11", lat, rd);
    end
    We0 = 1'b0; Addr0 = 2'd1; We1 = 1'b0; Addr1 = 2'd3;
    run_pair(1, 1);
    n_cmp++;
    if (ord_n !== 2) begin
      n_err++; $display("FAIL arb_rd_count: got %0d want 2", ord_n);
    end else begin
`ifdef SRAM_ARB_RR_EN
      n_cmp++;
      if ({ord_q[0], ord_q[1], ordd_q[0], ordd_q[1]} !== {32'd1, 32'd0, 8'h33, 8'h11}) begin
        n_err++; $display("FAIL arb_rd_order: got %0d%0d %h %h want 10 33 11",
                          ord_q[0], ord_q[1], ordd_q[0], ordd_q[1]);
      end
`else
      n_cmp++;
      if ({ord_q[0], ord_q[1], ordd_q[0], ordd_q[1]} !== {32'd0, 32'd1, 8'h11, 8'h33}) begin
        n_err++; $display("FAIL arb_rd_order: got %0d%0d %h %h want 01 11 33",
                          ord_q[0], ord_q[1], ordd_q[0], ordd_q[1]);
      end
`endif
    end
  endtask

  task automatic test_clear();
    logic [7:0] rd;
    int lat;
    ClrReq = 1'b1; Req0 = 1'b1; We0 = 1'b0; Addr0 = 2'd2;
    tick();
    n_cmp++;
    if ({Clear, ClrAck, Ack0, Read} !== 4'b0001) begin
      n_err++; $display("FAIL clr_first: got %b want 0001", {Clear, ClrAck, Ack0, Read});
    end
    tick();
    n_cmp++;
    if ({Clear, ClrAck, Ack0} !== 3'b110) begin
      n_err++; $display("FAIL clr_ack: got %b want 110", {Clear, ClrAck, Ack0});
    end
    ClrReq = 1'b0;
    tick();
    n_cmp++;
    if ({Clear, ClrAck, Ack0} !== 3'b100) begin
      n_err++; $display("FAIL clr_after: got %b want 100", {Clear, ClrAck, Ack0});
    end
    tick();
    n_cmp++;
    if ({Ack0, RData0} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL clr_rd_port0: got ack %b data %h want ack 1 data 00", Ack0, RData0);
    end
    Req0 = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      txn(1, 1'b0, a[1:0], 8'h00, rd, lat);
      n_cmp++;
      if ({lat, rd} !== {32'd2, 8'h00}) begin
        n_err++; $display("FAIL clr_readback addr %0d: got lat %0d data %h want lat 2 data 00", a, lat, rd);
      end
    end
  endtask

  task automatic test_reset_strobe();
    logic [7:0] rd;
    int lat;
    Req1 = 1'b1; We1 = 1'b1; Addr1 = 2'd0; WData1 = 8'h5C;
    tick();
    tick();
    n_cmp++;
    if (Read !== 1'b0) begin
      n_err++; $display("FAIL rst_strobe_pre: got Read %b want 0", Read);
    end
    Reset = 1'b1;
    tick();
    n_cmp++;
    if ({Read, Ack1, Clear} !== 3'b101) begin
      n_err++; $display("FAIL rst_strobe: got %b want 101", {Read, Ack1, Clear});
    end
    Reset = 1'b0;
    Req1  = 1'b0;
    tick();
    n_cmp++;
    if ({Read, Ack1} !== 2'b10) begin
      n_err++; $display("FAIL rst_strobe_after: got %b want 10", {Read, Ack1});
    end
    txn(0, 1'b0, 2'd0, 8'h00, rd, lat);
    n_cmp++;
    if ({lat, rd} !== {32'd2, 8'h5C}) begin
      n_err++; $display("FAIL rst_strobe_retained: got lat %0d data %h want lat 2 data 5c", lat, rd);
    end
  endtask

  task automatic test_hold_req();
    int acks;
    logic seen, rd_low;
    acks = 0; seen = 1'b0; rd_low = 1'b0;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!Read) rd_low = 1'b1;
      if (Ack0) begin
        acks++;
        seen = 1'b1;
      end else if (seen) begin
        Req0 = 1'b0;
      end
    end
    Req0 = 1'b0;
    n_cmp++;
    if (acks !== 1) begin
      n_err++; $display("FAIL hold_ack_count: got %0d want 1", acks);
    end
    n_cmp++;
    if ({rd_low, RData0} !== {1'b0, 8'h5C}) begin
      n_err++; $display("FAIL hold_data: got readlow %b data %h want 0 5c", rd_low, RData0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_clear();
    test_reset_strobe();
    test_hold_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
